// File: rtl/data_memory_responder.sv
// Data-port responder for the single-cycle CPU: word RAM plus an I/O page with
// a free-running cycle counter and a debug FIFO draining to a valid/ready sink.
module data_memory_responder #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] data_memory_addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        dbg_valid,
  output logic [31:0] dbg_data,
  input  logic        dbg_ready
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [29:0] CYCLE_IDX  = 30'h3FFF_FFC0;
  localparam logic [29:0] DBG_IDX    = 30'h3FFF_FFC1;
  localparam logic [29:0] STATUS_IDX = 30'h3FFF_FFC2;

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          overflow;
  logic [31:0]   cycle;

  logic          is_ram, sel_cycle, sel_dbg, sel_status;
  logic [AW-1:0] ram_idx;
  logic          empty, full, pop, push_req, push, ovf_set, ovf_clr;
  logic [31:0]   status;

  assign is_ram     = data_memory_addr < 32'(RAM_WORDS * 4);
  assign ram_idx    = data_memory_addr[AW+1:2];
  assign sel_cycle  = data_memory_addr[31:2] == CYCLE_IDX;
  assign sel_dbg    = data_memory_addr[31:2] == DBG_IDX;
  assign sel_status = data_memory_addr[31:2] == STATUS_IDX;

  assign empty    = count == '0;
  assign full     = count == (PW+1)'(FIFO_DEPTH);
  assign pop      = dbg_valid && dbg_ready;
  assign push_req = mem_write && sel_dbg;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = mem_write && sel_status && write_data[2];

  assign dbg_valid = !empty;
  assign dbg_data  = empty ? 32'h0 : fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (mem_write && is_ram) ram[ram_idx] <= write_data;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= write_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      cycle    <= 32'h0;
    end else begin
      cycle <= (mem_write && sel_cycle) ? write_data : cycle + 32'h1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_comb begin
    status       = 32'h0;
    status[0]    = empty;
    status[1]    = full;
    status[2]    = overflow;
    status[12:8] = 5'(count);
  end

  always_comb begin
    read_data = 32'h0;
    if (is_ram)          read_data = ram[ram_idx];
    else if (sel_cycle)  read_data = cycle;
    else if (sel_status) read_data = status;
  end
endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: RAM, cycle counter and debug FIFO.
module tb_data_memory_responder;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_FF00;
  localparam logic [31:0] A_DBG    = 32'hFFFF_FF04;
  localparam logic [31:0] A_STATUS = 32'hFFFF_FF08;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_write = 1'b0;
  logic [31:0] data_memory_addr = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data;
  logic        dbg_valid;
  logic [31:0] dbg_data;
  logic        dbg_ready = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] drained[$];

  data_memory_responder #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .mem_write(mem_write),
    .data_memory_addr(data_memory_addr), .write_data(write_data),
    .read_data(read_data), .dbg_valid(dbg_valid), .dbg_data(dbg_data),
    .dbg_ready(dbg_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus cycle: inputs already driven; sample at negedge, update model, pass the edge.
  task automatic step(input bit chk_rd, input string tag, input logic [31:0] exp_rd);
    int sz;
    logic do_push;
    @(negedge clk);
    if (chk_rd) check_eq(tag, read_data, exp_rd);
    sz = exp_q.size();
    check_eq("dbg_valid", {31'b0, dbg_valid}, {31'b0, sz != 0});
    check_eq("dbg_data", dbg_data, (sz != 0) ? exp_q[0] : 32'h0);
    if (!reset) begin
      do_push = mem_write && (data_memory_addr == A_DBG) && (sz < 4 || (dbg_ready && sz > 0));
      if (dbg_ready && sz > 0) drained.push_back(exp_q.pop_front());
      if (do_push) exp_q.push_back(write_data);
    end
    $display("cycle t=%0t we=%0b addr=%h wd=%h rd=%h valid=%0b data=%h ready=%0b q=%0d",
             $time, mem_write, data_memory_addr, write_data, read_data,
             dbg_valid, dbg_data, dbg_ready, exp_q.size());
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic we, input logic [31:0] a, input logic [31:0] d);
    mem_write = we;
    data_memory_addr = a;
    write_data = d;
  endtask

  initial begin
    int pushed;
    int guard;
    logic [31:0] exp_drain[4];
    exp_drain[0] = 32'd2; exp_drain[1] = 32'd3; exp_drain[2] = 32'd4; exp_drain[3] = 32'd9;

    // reset state
    bus(0, A_STATUS, 0);
    step(1, "reset_status", 32'h0000_0001);
    bus(0, A_CYCLE, 0);
    step(1, "reset_cycle", 32'h0);
    reset = 1'b0;
    bus(0, 32'h0000_1000, 0);
    for (int i = 0; i < 5; i++) step(0, "", 0);
    bus(0, A_CYCLE, 0);
    step(1, "cycle_after_5", 32'd5);

    // RAM
    bus(1, 32'h10, 32'h1111_1111);
    step(0, "", 0);
    bus(1, 32'h10, 32'hDEAD_BEEF);
    step(1, "ram_same_cycle_old", 32'h1111_1111);
    bus(0, 32'h10, 0);
    step(1, "ram_rd_10", 32'hDEAD_BEEF);
    bus(0, 32'h13, 0);
    step(1, "ram_rd_13", 32'hDEAD_BEEF);
    bus(0, 32'h1000, 0);
    step(1, "unmapped_rd", 32'h0);
    bus(0, A_DBG, 0);
    step(1, "dbg_data_rd", 32'h0);

    // counter wrap
    bus(1, A_CYCLE, 32'hFFFF_FFFE);
    step(0, "", 0);
    bus(0, A_CYCLE, 0);
    step(1, "cycle_load", 32'hFFFF_FFFE);
    step(1, "cycle_max", 32'hFFFF_FFFF);
    step(1, "cycle_wrap", 32'h0);

    // fill and overflow
    dbg_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus(1, A_DBG, i);
      step(0, "", 0);
    end
    bus(0, A_STATUS, 0);
    step(1, "status_full", 32'h0000_0402);
    bus(1, A_DBG, 32'd5);
    step(0, "", 0);
    bus(0, A_STATUS, 0);
    step(1, "status_overflow", 32'h0000_0406);
    check_eq("head_after_ovf", dbg_data, 32'd1);
    bus(1, A_STATUS, 32'h4);
    step(0, "", 0);
    bus(0, A_STATUS, 0);
    step(1, "status_ovf_clr", 32'h0000_0402);

    // full with simultaneous push and pop
    dbg_ready = 1'b1;
    bus(1, A_DBG, 32'd9);
    step(0, "", 0);
    dbg_ready = 1'b0;
    bus(0, A_STATUS, 0);
    step(1, "status_push_pop_full", 32'h0000_0402);
    drained.delete();
    dbg_ready = 1'b1;
    for (int i = 0; i < 4; i++) step(0, "", 0);
    check_eq("drain_count", drained.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("drain_%0d", i), (i < drained.size()) ? drained[i] : 32'hX, exp_drain[i]);
    check_eq("empty_after_drain", {31'b0, dbg_valid}, 32'h0);

    // backpressure with random ready
    pushed = 0;
    guard = 0;
    while (pushed < 20 && guard < 400) begin
      dbg_ready = 1'($urandom_range(0, 1));
      if (exp_q.size() < 4 && $urandom_range(0, 1) == 1) begin
        bus(1, A_DBG, 32'h100 + pushed);
        pushed++;
      end else begin
        bus(0, 32'h1000, 0);
      end
      step(0, "", 0);
      guard++;
    end
    check_eq("bp_pushes_done", pushed, 32'd20);
    bus(0, 32'h1000, 0);
    dbg_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      step(0, "", 0);
      guard++;
    end
    check_eq("bp_drained", exp_q.size(), 32'd0);

    // async reset mid-stream
    dbg_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus(1, A_DBG, 32'hA0 + i);
      step(0, "", 0);
    end
    bus(0, A_STATUS, 0);
    check_eq("queued_3", {31'b0, dbg_valid}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check_eq("async_valid_drop", {31'b0, dbg_valid}, 32'h0);
    check_eq("async_data_zero", dbg_data, 32'h0);
    exp_q.delete();
    step(0, "", 0);
    reset = 1'b0;
    step(1, "status_after_reset", 32'h0000_0001);
    bus(0, A_CYCLE, 0);
    step(1, "cycle_after_release", 32'd1);
    bus(0, 32'h10, 0);
    step(1, "ram_preserved", 32'hDEAD_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
